m_dmem_resp: RTL

M_DMEM_RESP -- requirements
Module: m_dmem_resp

---
 rtl/m_dmem_resp_pkg.sv | 32 +++
 rtl/m_dmem_ram.sv | 30 +++
 rtl/m_dmem_resp.sv | 130 +++++++++++++
 3 files changed

// File: rtl/m_dmem_resp_pkg.sv
// Shared types and constants for the data-memory responder.
// Holds the FSM state type (WAIT only exists when DMEM_WAIT_EN is defined),
// default geometry and the MEM-stage load/store opcodes.
package m_dmem_resp_pkg;

  localparam int DMEM_ADDR_W = 11;
  localparam int DMEM_DATA_W = 32;

  localparam logic [5:0] LW = 6'h23;
  localparam logic [5:0] SW = 6'h2b;

`ifdef DMEM_WAIT_EN
  typedef enum logic [1:0] {
    S_IDLE   = 2'd0,
    S_ACCESS = 2'd1,
    S_WAIT   = 2'd2,
    S_RESP   = 2'd3
  } dmem_state_e;
`else
  typedef enum logic [1:0] {
    S_IDLE   = 2'd0,
    S_ACCESS = 2'd1,
    S_RESP   = 2'd3
  } dmem_state_e;
`endif

  // Decode helper for the processor side: true for LW or SW.
  function automatic logic is_mem_op(input logic [5:0] op);
    return (op == LW) || (op == SW);
  endfunction

endpackage

// File: rtl/m_dmem_ram.sv
// Purpose: single-port 2^ADDR_W x DATA_W synchronous RAM, no reset.
// Latency: write and read both take effect at the enabled edge; dout is registered.
// Backpressure: none; accepts one access per enabled cycle. Contents are
// preloaded by the program loader and are never cleared.
module m_dmem_ram #(
  parameter int ADDR_W = 11,
  parameter int DATA_W = 32
) (
  input  logic              w_clk,
  input  logic              en,
  input  logic              we,
  input  logic [ADDR_W-1:0] addr,
  input  logic [DATA_W-1:0] din,
  output logic [DATA_W-1:0] dout
);

  logic [DATA_W-1:0] mem [2**ADDR_W];

  // Write on a store, register the read word on a load; dout holds otherwise.
  always_ff @(posedge w_clk) begin
    if (en) begin
      if (we) begin
        mem[addr] <= din;
      end else begin
        dout <= mem[addr];
      end
    end
  end

endmodule

// File: rtl/m_dmem_resp.sv
// Purpose: request/ack data-memory responder for the processor MEM stage.
// Latency: accept edge to r_ack is 2 cycles (+WAIT_CYC when DMEM_WAIT_EN is defined).
// Backpressure: r_ready only in IDLE; requests while busy are ignored, the requester holds w_req.
module m_dmem_resp
  import m_dmem_resp_pkg::*;
#(
  parameter int ADDR_W   = DMEM_ADDR_W,
  parameter int DATA_W   = DMEM_DATA_W,
  parameter int WAIT_CYC = 2
) (
  input  logic              w_clk,
  input  logic              w_rst_n,
  input  logic              w_req,
  input  logic              w_we,
  input  logic [ADDR_W-1:0] w_addr,
  input  logic [DATA_W-1:0] w_din,
  output logic              r_ready,
  output logic              r_ack,
  output logic [DATA_W-1:0] r_dout
);

  dmem_state_e       state_q, state_d;
  logic              rst_done_q;
  logic              accept;
  logic              we_q;
  logic [ADDR_W-1:0] addr_q;
  logic [DATA_W-1:0] din_q;
  logic [DATA_W-1:0] dout_q;
  logic [DATA_W-1:0] ram_dout;
  logic              ram_en;
  logic              load_resp;

  // rst_done_q keeps r_ready low until the first edge after reset release.
  assign r_ready   = rst_done_q && (state_q == S_IDLE);
  assign accept    = w_req && r_ready;
  assign r_ack     = (state_q == S_RESP);
  assign load_resp = (state_q == S_RESP) && !we_q;
  // The RAM read lands when leaving ACCESS but only becomes visible in RESP.
  assign r_dout    = load_resp ? ram_dout : dout_q;

`ifdef DMEM_WAIT_EN
  localparam int CNT_W = (WAIT_CYC > 1) ? $clog2(WAIT_CYC) : 1;
  logic [CNT_W-1:0] wait_cnt_q;

  // Preload the remaining-wait count while in ACCESS, then count down in WAIT.
  always_ff @(posedge w_clk or negedge w_rst_n) begin
    if (!w_rst_n) begin
      wait_cnt_q <= '0;
    end else if (state_q == S_ACCESS) begin
      wait_cnt_q <= CNT_W'(WAIT_CYC - 1);
    end else if ((state_q == S_WAIT) && (wait_cnt_q != '0)) begin
      wait_cnt_q <= wait_cnt_q - 1'b1;
    end
  end
`else
  logic [31:0] unused_wait_cyc;
  assign unused_wait_cyc = WAIT_CYC;
`endif

  // State register, reset-release flag and request latches.
  always_ff @(posedge w_clk or negedge w_rst_n) begin
    if (!w_rst_n) begin
      state_q    <= S_IDLE;
      rst_done_q <= 1'b0;
      we_q       <= 1'b0;
      addr_q     <= '0;
      din_q      <= '0;
    end else begin
      state_q    <= state_d;
      rst_done_q <= 1'b1;
      if (accept) begin
        we_q   <= w_we;
        addr_q <= w_addr;
        din_q  <= w_din;
      end
    end
  end

  // Load data is captured as the response retires so r_dout holds until the next load.
  always_ff @(posedge w_clk or negedge w_rst_n) begin
    if (!w_rst_n) begin
      dout_q <= '0;
    end else if (load_resp) begin
      dout_q <= ram_dout;
    end
  end

  // Next-state logic; the RAM is enabled only for the single ACCESS cycle.
  always_comb begin
    state_d = state_q;
    ram_en  = 1'b0;
    case (state_q)
      S_IDLE: begin
        if (accept) state_d = S_ACCESS;
      end
      S_ACCESS: begin
        ram_en  = 1'b1;
`ifdef DMEM_WAIT_EN
        state_d = (WAIT_CYC > 0) ? S_WAIT : S_RESP;
`else
        state_d = S_RESP;
`endif
      end
`ifdef DMEM_WAIT_EN
      S_WAIT: begin
        if (wait_cnt_q == '0) state_d = S_RESP;
      end
`endif
      S_RESP: begin
        state_d = S_IDLE;
      end
      default: begin
        state_d = S_IDLE;
      end
    endcase
  end

  m_dmem_ram #(
    .ADDR_W (ADDR_W),
    .DATA_W (DATA_W)
  ) u_ram (
    .w_clk (w_clk),
    .en    (ram_en),
    .we    (we_q),
    .addr  (addr_q),
    .din   (din_q),
    .dout  (ram_dout)
  );

endmodule
